div_arbiter: RTL and testbench

Two-port controller that shares the single 32-bit iterative `divison` unit between two requesters. It arbitrates round-robin and latches the winner's operands. It pulses the divider's `start`, waits for `done`, applies signed pre/post correction, and returns the result to the winner. Divide-by-zero requests are answered directly, without using the divider. The block sits between the two ALU-side clients and the divider instance, and is the only driver of the divider's `start`, `dividend` and `divisor`.

---
 rtl/div_arb_pkg.sv | 7 +
 rtl/div_sign_fix.sv | 10 +
 rtl/div_arbiter.sv | 142 ++++++++++++++
 tb/tb_div_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;
  localparam int DIV_W = 32;
  localparam logic [DIV_W-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate, used for operand magnitudes and result signs.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? (~a + WIDTH'(1)) : a;
endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one unsigned iterative divider between two
// requesters, with signed pre/post correction, divide-by-zero bypass and watchdog.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int WIDTH   = DIV_W,
  parameter int TIMEOUT = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_dividend0,
  input  logic [WIDTH-1:0] req_dividend1,
  input  logic [WIDTH-1:0] req_divisor0,
  input  logic [WIDTH-1:0] req_divisor1,
  input  logic [1:0]       req_signed,
  output logic [1:0]       rsp_valid,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_dbz,
  output logic             rsp_err,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  state_t           state;
  logic             last, owner, qneg, rneg;
  logic [WIDTH-1:0] magD, magV, resQ, resR;
  logic [WDW-1:0]   wdog;
  logic [1:0]       rspValidR;
  logic             dbzR, errR, startR;

  logic [1:0]       grant;
  logic             selId, selS, sd, sv, accept;
  logic [WIDTH-1:0] selD, selV, magDIn, magVIn, fixQ, fixR;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req_valid;
    if (req_valid == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign selId     = grant[1];
  assign selD      = selId ? req_dividend1 : req_dividend0;
  assign selV      = selId ? req_divisor1  : req_divisor0;
  assign selS      = req_signed[selId];
  assign sd        = selS & selD[WIDTH-1];
  assign sv        = selS & selV[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) uFixD (.neg(sd),   .a(selD),          .y(magDIn));
  div_sign_fix #(.WIDTH(WIDTH)) uFixV (.neg(sv),   .a(selV),          .y(magVIn));
  div_sign_fix #(.WIDTH(WIDTH)) uFixQ (.neg(qneg), .a(div_quotient),  .y(fixQ));
  div_sign_fix #(.WIDTH(WIDTH)) uFixR (.neg(rneg), .a(div_remainder), .y(fixR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      qneg      <= 1'b0;
      rneg      <= 1'b0;
      magD      <= '0;
      magV      <= '0;
      resQ      <= '0;
      resR      <= '0;
      wdog      <= '0;
      rspValidR <= 2'b00;
      dbzR      <= 1'b0;
      errR      <= 1'b0;
      startR    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          owner <= selId;
          last  <= selId;
          qneg  <= sd ^ sv;
          rneg  <= sd;
          magD  <= magDIn;
          magV  <= magVIn;
          dbzR  <= 1'b0;
          errR  <= 1'b0;
          if (selV == '0) begin
            // Answered without touching the divider.
            resQ      <= DBZ_QUOTIENT;
            resR      <= selD;
            dbzR      <= 1'b1;
            rspValidR <= {selId, ~selId};
            state     <= RESP;
          end else begin
            startR <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          startR <= 1'b0;
          wdog   <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            resQ      <= fixQ;
            resR      <= fixR;
            rspValidR <= {owner, ~owner};
            state     <= RESP;
          end else if (wdog == WDW'(TIMEOUT - 1)) begin
            errR      <= 1'b1;
            resQ      <= '0;
            resR      <= '0;
            rspValidR <= {owner, ~owner};
            state     <= RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        RESP: begin
          rspValidR <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid     = rspValidR;
  assign rsp_quotient  = resQ;
  assign rsp_remainder = resR;
  assign rsp_dbz       = dbzR;
  assign rsp_err       = errR;
  assign busy          = (state != IDLE);
  assign div_start     = startR;
  assign div_dividend  = magD;
  assign div_divisor   = magV;
endmodule

// File: tb/tb_div_arbiter.sv
// Randomized bench for div_arbiter with a behavioural divider and arithmetic reference.
module tb_div_arbiter;
  localparam int W  = 32;
  localparam int TO = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   reqValid = 2'b00, reqSigned = 2'b00, reqReady, rspValid;
  logic [W-1:0] d0 = '0, d1 = '0, v0 = '0, v1 = '0;
  logic [W-1:0] rspQ, rspR, divDividend, divDivisor, divQ, divR;
  logic         rspDbz, rspErr, busy, divStart, divDone;
  int           total = 0, bad = 0;
  bit           tieLow = 1'b0;

  div_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_dividend0(d0), .req_dividend1(d1),
    .req_divisor0(v0), .req_divisor1(v1),
    .req_signed(reqSigned),
    .rsp_valid(rspValid), .rsp_quotient(rspQ), .rsp_remainder(rspR),
    .rsp_dbz(rspDbz), .rsp_err(rspErr), .busy(busy),
    .div_start(divStart), .div_dividend(divDividend), .div_divisor(divDivisor),
    .div_done(divDone), .div_quotient(divQ), .div_remainder(divR)
  );

  // Behavioural unsigned divider: random latency, done held until the next start.
  logic [W-1:0] ma, mb;
  int           mcnt;
  bit           mbusy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      divDone <= 1'b0; mbusy <= 1'b0; mcnt <= 0;
      divQ <= '0; divR <= '0; ma <= '0; mb <= '0;
    end else if (divStart) begin
      divDone <= 1'b0; mbusy <= 1'b1; mcnt <= int'($urandom_range(40, 2));
      ma <= divDividend; mb <= divDivisor;
    end else if (mbusy) begin
      if (mcnt == 0) begin
        mbusy <= 1'b0;
        if (!tieLow) begin
          divDone <= 1'b1; divQ <= ma / mb; divR <= ma % mb;
        end
      end else mcnt <= mcnt - 1;
    end
  end

  function automatic void refDiv(input logic [W-1:0] a, b, input logic s,
                                 output logic [W-1:0] q, r, output logic dz);
    longint la, lb, lq, lr;
    dz = (b == '0);
    if (dz) begin
      q = '1; r = a;
    end else if (s) begin
      la = longint'($signed(a)); lb = longint'($signed(b));
      lq = la / lb; lr = la % lb;
      q = lq[W-1:0]; r = lr[W-1:0];
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Drives one request from requester id and waits for its response.
  task automatic doReq(input int id, input logic [W-1:0] a, b, input logic s,
                       output logic [1:0] rv, output logic [W-1:0] q, r,
                       output logic dz, er, output int lat, output int starts);
    int n = 0;
    if (id == 0) begin d0 = a; v0 = b; end else begin d1 = a; v1 = b; end
    reqSigned[id] = s;
    reqValid[id]  = 1'b1;
    #1;
    while (!reqReady[id] && n < 100) begin @(negedge clk); n++; end
    total++;
    if (n >= 100) begin bad++; $display("FAIL accept r%0d: ready=%b never granted", id, reqReady); end
    @(negedge clk);
    reqValid[id] = 1'b0;
    lat = 1; starts = 0;
    while (rspValid == 2'b00 && lat < 200) begin
      starts += int'(divStart);
      @(negedge clk);
      lat++;
    end
    rv = rspValid; q = rspQ; r = rspR; dz = rspDbz; er = rspErr;
  endtask

  task automatic pulseReset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    reqValid = 2'b11; d0 = 32'd9; v0 = 32'd3; d1 = 32'd8; v1 = 32'd2;
    repeat (2) @(negedge clk);
    total++;
    if ({reqReady, rspValid, busy, divStart, rspDbz, rspErr} !== 8'b0) begin
      bad++; $display("FAIL reset ctrl: ready=%b rv=%b busy=%b start=%b dbz=%b err=%b",
                      reqReady, rspValid, busy, divStart, rspDbz, rspErr);
    end
    total++;
    if (rspQ !== '0 || rspR !== '0) begin
      bad++; $display("FAIL reset data: q=%h r=%h want 0 0", rspQ, rspR);
    end
    rst = 1'b0;
    #1;
    total++;
    if (reqReady !== 2'b01) begin bad++; $display("FAIL first tie: ready=%b want 01", reqReady); end
    reqValid = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    logic [1:0] rv; logic [W-1:0] q, r; logic dz, er; int lat, st;
    doReq(0, 32'd100, 32'd7, 1'b0, rv, q, r, dz, er, lat, st);
    total++;
    if ({rv, q, r, dz, er} !== {2'b01, 32'd14, 32'd2, 2'b00}) begin
      bad++; $display("FAIL unsigned 100/7: rv=%b q=%0d r=%0d dbz=%b err=%b want 01 14 2 0 0", rv, q, r, dz, er);
    end
    total++;
    if (st != 1) begin bad++; $display("FAIL unsigned start count: got %0d want 1", st); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL unsigned busy after: got %b want 0", busy); end
  endtask

  task automatic test_signed();
    logic [W-1:0] da[3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [W-1:0] va[3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
    logic [W-1:0] qa[3] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
    logic [W-1:0] ra[3] = '{32'hFFFFFFFF, 32'd1, 32'd0};
    logic [1:0] rv; logic [W-1:0] q, r; logic dz, er; int lat, st;
    for (int i = 0; i < 3; i++) begin
      doReq(1, da[i], va[i], 1'b1, rv, q, r, dz, er, lat, st);
      total++;
      if ({rv, q, r, dz, er} !== {2'b10, qa[i], ra[i], 2'b00}) begin
        bad++; $display("FAIL signed case %0d: rv=%b q=%h r=%h dbz=%b err=%b want 10 %h %h 0 0",
                        i, rv, q, r, dz, er, qa[i], ra[i]);
      end
    end
  endtask

  task automatic test_dbz();
    logic [1:0] rv; logic [W-1:0] q, r; logic dz, er; int lat, st;
    doReq(0, 32'd5, 32'd0, 1'b0, rv, q, r, dz, er, lat, st);
    total++;
    if ({rv, q, r, dz, er} !== {2'b01, 32'hFFFFFFFF, 32'd5, 2'b10}) begin
      bad++; $display("FAIL dbz 5/0: rv=%b q=%h r=%0d dbz=%b err=%b want 01 ffffffff 5 1 0", rv, q, r, dz, er);
    end
    total++;
    if (lat != 1 || st != 0) begin
      bad++; $display("FAIL dbz timing: latency=%0d starts=%0d want 1 0", lat, st);
    end
  endtask

  task automatic test_contention();
    logic [W-1:0] q, r; logic dz; logic [1:0] g, want; int n, id, served;
    pulseReset();
    served = 0;
    d0 = $urandom; v0 = $urandom_range(1000, 1); d1 = $urandom; v1 = $urandom_range(1000, 1);
    reqSigned = 2'($urandom);
    reqValid  = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0; #1;
      while (reqReady == 2'b00 && n < 100) begin @(negedge clk); n++; end
      g = reqReady; want = (k % 2 == 0) ? 2'b01 : 2'b10; id = int'(g[1]);
      total++;
      if (g !== want) begin bad++; $display("FAIL contention grant %0d: got %b want %b", k, g, want); end
      if (id == 0) refDiv(d0, v0, reqSigned[0], q, r, dz);
      else         refDiv(d1, v1, reqSigned[1], q, r, dz);
      @(negedge clk);
      n = 0;
      while (rspValid == 2'b00 && n < 200) begin @(negedge clk); n++; end
      if (rspValid != 2'b00) served++;
      total++;
      if ({rspValid, rspQ, rspR} !== {g, q, r}) begin
        bad++; $display("FAIL contention rsp %0d: rv=%b q=%h r=%h want %b %h %h", k, rspValid, rspQ, rspR, g, q, r);
      end
      if (id == 0) begin d0 = $urandom; v0 = $urandom_range(1000, 1); end
      else         begin d1 = $urandom; v1 = $urandom_range(1000, 1); end
    end
    reqValid = 2'b00;
    total++;
    if (served != 4) begin bad++; $display("FAIL contention responses: got %0d want 4", served); end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(5, 0))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'd1;
      3: return $urandom_range(20, 0);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0] rv; logic [W-1:0] a, b, q, r, eq, erm; logic dz, er, s, edz; int lat, st, id;
    for (int i = 0; i < 24; i++) begin
      id = int'($urandom_range(1, 0)); s = 1'($urandom);
      a = pick(); b = ($urandom_range(7, 0) == 0) ? '0 : pick();
      refDiv(a, b, s, eq, erm, edz);
      doReq(id, a, b, s, rv, q, r, dz, er, lat, st);
      total++;
      if ({rv, q, r, dz, er} !== {(id == 1) ? 2'b10 : 2'b01, eq, erm, edz, 1'b0} || st != (edz ? 0 : 1)) begin
        bad++; $display("FAIL random %0d %h/%h s=%b: rv=%b q=%h r=%h dbz=%b err=%b starts=%0d want q=%h r=%h dbz=%b",
                        i, a, b, s, rv, q, r, dz, er, st, eq, erm, edz);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [1:0] rv; logic [W-1:0] q, r; logic dz, er; int lat, st, n, seen;
    tieLow = 1'b1;
    doReq(1, 32'd1000, 32'd3, 1'b0, rv, q, r, dz, er, lat, st);
    total++;
    if ({rv, q, r, dz, er} !== {2'b10, 64'd0, 2'b01}) begin
      bad++; $display("FAIL watchdog rsp: rv=%b q=%h r=%h dbz=%b err=%b want 10 0 0 0 1", rv, q, r, dz, er);
    end
    total++;
    if (lat != TO + 2) begin bad++; $display("FAIL watchdog latency: got %0d want %0d", lat, TO + 2); end
    // Abort an in-flight request with reset while it sits in WAIT.
    @(negedge clk);
    d0 = 32'd77; v0 = 32'd4; reqSigned[0] = 1'b0; reqValid[0] = 1'b1;
    n = 0; #1;
    while (!reqReady[0] && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    reqValid[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; #1;
    total++;
    if ({busy, rspValid, divStart, rspErr} !== 5'b0) begin
      bad++; $display("FAIL reset mid-wait: busy=%b rv=%b start=%b err=%b want all 0", busy, rspValid, divStart, rspErr);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rspValid != 2'b00 || busy) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL dropped request: %0d cycles with rsp_valid or busy, want 0", seen); end
    tieLow = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_dbz();
    test_contention();
    test_random();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
